// File: rtl/div_issue_pkg.sv
// Shared encodings for the EX-stage divide initiator: FSM states and divider handshake levels.
package div_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic        RST_ENABLE           = 1'b1;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

endpackage

// File: rtl/div_issue_if.sv
// Handshake bundle between the EX-stage divide initiator (master) and the multi-cycle divider (slave).
interface div_issue_if #(
    parameter int DATA_W = 32
);
    logic                  div_signed;
    logic [DATA_W-1:0]     div_op1;
    logic [DATA_W-1:0]     div_op2;
    logic                  div_start;
    logic                  div_annul;
    logic [2*DATA_W-1:0]   div_result;
    logic                  div_ready;

    modport master (
        output div_signed, div_op1, div_op2, div_start, div_annul,
        input  div_result, div_ready
    );

    modport slave (
        input  div_signed, div_op1, div_op2, div_start, div_annul,
        output div_result, div_ready
    );
endinterface

// File: rtl/div_issue.sv
// EX-stage DIV/DIVU initiator: launches the divider, stalls EX until ready, presents HI/LO.
// Optional build macro DIV_ZERO_SHORTCUT_EN resolves zero-divisor ops locally (adds div_zero_o).
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              stallreq_o,
    output logic              result_valid_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
`ifdef DIV_ZERO_SHORTCUT_EN
    output logic              div_zero_o,
`endif
    div_issue_if.master       div
);

    state_t            r_state;
    state_t            w_next;
    logic              r_start;
    logic              r_signed;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              w_launch;
    logic              w_zero_op;
    logic              w_stallreq;
    logic              w_annul;
    logic              w_valid;
    logic              w_capture;

    // A divider still holding ready from the previous op must drop it before we relaunch.
    assign w_launch  = req_i & ~flush_i & (div.div_ready == DIV_RESULT_NOT_READY);
    assign w_capture = (r_state == ST_BUSY) & ~flush_i & (div.div_ready == DIV_RESULT_READY);

`ifdef DIV_ZERO_SHORTCUT_EN
    logic r_zero;
    assign w_zero_op  = (op2_i == ZERO_WORD);
    assign div_zero_o = w_valid & r_zero;
`else
    assign w_zero_op  = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_stallreq = 1'b0;
        w_annul    = 1'b0;
        w_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stallreq = req_i & ~flush_i;
                if (w_launch) begin
                    w_next = w_zero_op ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stallreq = 1'b1;
                if (flush_i) begin
                    w_annul = 1'b1;
                    w_next  = ST_IDLE;
                end else if (div.div_ready == DIV_RESULT_READY) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_valid = ~flush_i;
                if (~stall_i | flush_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state  <= ST_IDLE;
            r_start  <= DIV_STOP;
            r_signed <= 1'b0;
            r_op1    <= ZERO_WORD;
            r_op2    <= ZERO_WORD;
            r_hi     <= ZERO_WORD;
            r_lo     <= ZERO_WORD;
`ifdef DIV_ZERO_SHORTCUT_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // Start is held for the whole BUSY residency and dropped on exit to free the divider.
            r_start <= (w_next == ST_BUSY) ? DIV_START : DIV_STOP;
            if ((r_state == ST_IDLE) && w_launch) begin
                r_signed <= signed_i;
                r_op1    <= op1_i;
                r_op2    <= op2_i;
`ifdef DIV_ZERO_SHORTCUT_EN
                r_zero   <= w_zero_op;
                if (w_zero_op) begin
                    r_hi <= ZERO_WORD;
                    r_lo <= ZERO_WORD;
                end
`endif
            end
            if (w_capture) begin
                r_hi <= div.div_result[2*DATA_W-1:DATA_W];
                r_lo <= div.div_result[DATA_W-1:0];
            end
        end
    end

    assign stallreq_o     = w_stallreq;
    assign result_valid_o = w_valid;
    assign hi_o           = w_valid ? r_hi : ZERO_WORD;
    assign lo_o           = w_valid ? r_lo : ZERO_WORD;

    assign div.div_signed = r_signed;
    assign div.div_op1    = r_op1;
    assign div.div_op2    = r_op2;
    assign div.div_start  = r_start;
    assign div.div_annul  = w_annul;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural multi-cycle divider and a result scoreboard.
module tb_div_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, signed_i, flush_i, stall_i;
    logic [31:0] op1_i, op2_i;
    logic        stallreq_o, result_valid_o;
    logic [31:0] hi_o, lo_o;
`ifdef DIV_ZERO_SHORTCUT_EN
    logic        div_zero_o;
`endif

    div_issue_if #(.DATA_W(32)) dv ();

    div_issue #(.DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .signed_i       (signed_i),
        .op1_i          (op1_i),
        .op2_i          (op2_i),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .stallreq_o     (stallreq_o),
        .result_valid_o (result_valid_o),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
`ifdef DIV_ZERO_SHORTCUT_EN
        .div_zero_o     (div_zero_o),
`endif
        .div            (dv)
    );

    always #5 clk = ~clk;

    // Behavioural divider: fixed 34-cycle latency, ready held until start drops, annul aborts.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    logic [1:0]  dst;
    int          dcnt;
    logic        dsg;
    logic [31:0] da, db;
    always @(posedge clk) begin
        if (rst) begin
            dst           <= 2'd0;
            dcnt          <= 0;
            dv.div_ready  <= 1'b0;
            dv.div_result <= 64'd0;
        end else begin
            case (dst)
                2'd0: if (dv.div_start && !dv.div_annul) begin
                    dst  <= 2'd1;
                    dcnt <= 0;
                    dsg  <= dv.div_signed;
                    da   <= dv.div_op1;
                    db   <= dv.div_op2;
                end
                2'd1: if (dv.div_annul) begin
                    dst <= 2'd0;
                end else if (dcnt == 33) begin
                    dst           <= 2'd2;
                    dv.div_ready  <= 1'b1;
                    dv.div_result <= ref_div(dsg, da, db);
                end else begin
                    dcnt <= dcnt + 1;
                end
                default: if (!dv.div_start) begin
                    dst           <= 2'd0;
                    dv.div_ready  <= 1'b0;
                    dv.div_result <= 64'd0;
                end
            endcase
        end
    end

    // Start-edge monitor: counts launches and flags any launch while the divider still shows ready.
    logic prev_start;
    int   start_cnt;
    logic bad_start;
    always @(posedge clk) begin
        if (rst) begin
            prev_start <= 1'b0;
            bad_start  <= 1'b0;
            start_cnt  <= 0;
        end else begin
            prev_start <= dv.div_start;
            if (dv.div_start && !prev_start) begin
                start_cnt <= start_cnt + 1;
                if (dv.div_ready) bad_start <= 1'b1;
            end
        end
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {stallreq_o, result_valid_o, hi_o, lo_o}, 66'd0);
        chk({tag, "_div"}, {dv.div_start, dv.div_annul, dv.div_signed, dv.div_op1, dv.div_op2}, 67'd0);
    endtask

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_zero, input int nstall, output int lat);
        exp_t        e;
        bit          got, stall_ok;
        logic [31:0] h0, l0;
        e.hi = exp_hi; e.lo = exp_lo; e.zero = exp_zero;
        sb.push_back(e);
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = s; op1_i = a; op2_i = b;
        got = 1'b0; stall_ok = 1'b1; lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (result_valid_o) begin
                got = 1'b1;
                lat = n;
                break;
            end
            if (!stallreq_o) stall_ok = 1'b0;
        end
        chk("stallreq_while_waiting", {63'd0, stall_ok}, 64'd1);
        chk("result_arrived", {63'd0, got}, 64'd1);
        e = sb.pop_front();
        if (got) begin
            chk("hi", {32'd0, hi_o}, {32'd0, e.hi});
            chk("lo", {32'd0, lo_o}, {32'd0, e.lo});
            chk("stallreq_in_done", {63'd0, stallreq_o}, 64'd0);
`ifdef DIV_ZERO_SHORTCUT_EN
            chk("div_zero", {63'd0, div_zero_o}, {63'd0, e.zero});
`endif
            h0 = hi_o; l0 = lo_o;
            if (nstall > 0) begin
                stall_i = 1'b1;
                repeat (nstall) begin
                    @(negedge clk);
                    chk("stall_hold", {result_valid_o, hi_o, lo_o}, {1'b1, h0, l0});
                end
                stall_i = 1'b0;
            end
        end
    endtask

    task automatic idle_step(input string tag);
        @(posedge clk); #1;
        req_i = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_one_cycle"}, {62'd0, result_valid_o, stallreq_o}, 64'd0);
    endtask

    initial begin
        int lat, busy, spurious, snap;
        rst = 1'b1; req_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        op1_i = 32'd0; op2_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: signed -7/2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, lat);
        idle_step("div_neg");

        // 2: unsigned cases
        issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, lat);
        idle_step("divu_100_7");
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, lat);
        idle_step("divu_max_1");

        // 3: flush on the 10th BUSY cycle
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = 1'b0; op1_i = 32'd50; op2_i = 32'd5;
        busy = 0;
        for (int n = 0; n < 100 && busy < 9; n++) begin
            @(negedge clk);
            if (dv.div_start) busy++;
        end
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_cycle", {dv.div_start, dv.div_annul, result_valid_o}, {1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        flush_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        chk("after_flush", {dv.div_start, dv.div_annul, stallreq_o}, 3'b000);
        spurious = 0;
        repeat (45) begin
            @(negedge clk);
            if (result_valid_o) spurious++;
        end
        chk("no_result_after_flush", spurious, 0);
        issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 0, lat);
        idle_step("divu_9_3");

        // 4: back-to-back ops, second launch must wait for ready to drop
        issue(1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 1'b0, 0, lat);
        issue(1'b0, 32'd21, 32'd4, 32'd1, 32'd5, 1'b0, 0, lat);
        idle_step("b2b");
        chk("no_start_while_ready", {63'd0, bad_start}, 64'd0);

        // 5: zero divisor
        snap = start_cnt;
        issue(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 0, lat);
`ifdef DIV_ZERO_SHORTCUT_EN
        chk("zero_latency", lat, 1);
        chk("zero_no_start", start_cnt, snap);
`else
        chk("zero_issued", {63'd0, (start_cnt > snap)}, 64'd1);
`endif
        idle_step("div_zero");

        // 6a: downstream stall holds the result
        issue(1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 1'b0, 3, lat);
        idle_step("stall_done");

        // 6b: reset while BUSY
        @(posedge clk); #1;
        req_i = 1'b1; signed_i = 1'b1; op1_i = 32'd1000; op2_i = 32'd3;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1; req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_mid_busy");
        @(posedge clk); #1;
        rst = 1'b0;

        // signed 100 / -3 after reset
        issue(1'b1, 32'd100, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFDF, 1'b0, 0, lat);
        idle_step("div_pos_neg");

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
